mux_4to1_rr_arbiter: RTL and testbench

- Shares a single 4-to-1 data mux between four requesters (ports a, b, c, d) using round-robin arbitration.
- Drives the mux select, issues one-hot grants, and presents the muxed word downstream with a valid/ready handshake.
- Bounds each grant to a maximum burst of accepted beats so no requester can starve the others.
- Sits between four producer channels and a single shared consumer.

---
 rtl/mux_4to1_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_arbiter.sv
// Four-channel round-robin arbiter that drives a shared 4-to-1 data mux, with a per-grant burst limit.
// Define MUX_ARB_FIXED_PRIO_EN to switch IDLE arbitration to fixed priority (0 > 1 > 2 > 3).
module mux_4to1_rr_arbiter #(
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             out_ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state;
   logic [1:0]    last;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [1:0]    winner;
   logic [1:0]    cand;
   logic          accept;
   logic          rel;

   // Handshake: a beat transfers on every cycle where out_valid && out_ready are both high;
   // out_valid never waits on out_ready, and it falls as soon as the granted request drops.
   assign busy      = (state == GRANT);
   assign out_valid = busy && req[sel];
   assign accept    = out_valid && out_ready;
   assign cnt_inc   = cnt + CW'(1);

   // Release on a dropped request, or on the beat that completes the burst.
   assign rel = busy && (!req[sel] || (accept && (cnt_inc == CW'(MAX_BURST))));

`ifdef MUX_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = 2'd0;
      cand   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) winner = 2'(i);
      end
   end
`else
   // Offset 1 is scanned last so it wins; offset 4 wraps back to the last winner itself.
   always_comb begin
      winner = last;
      cand   = last;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (req[cand]) winner = cand;
      end
   end
`endif

   always_comb begin
      case (sel)
         2'd0:    out = a;
         2'd1:    out = b;
         2'd2:    out = c;
         default: out = d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         last  <= 2'd3;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req != 4'b0000) begin
                  state <= GRANT;
                  gnt   <= 4'b0001 << winner;
                  sel   <= winner;
                  cnt   <= '0;
               end
            end
            default: begin
               if (rel) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  last  <= sel;
                  cnt   <= '0;
               end else if (accept) begin
                  cnt <= cnt_inc;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Directed bench for mux_4to1_rr_arbiter: inputs change and outputs are checked on the falling edge.
// Build with MUX_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_mux_4to1_rr_arbiter;

   localparam int WIDTH     = 4;
   localparam int MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req;
   logic [WIDTH-1:0] a, b, c, d;
   logic             out_ready;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux_4to1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .out_ready(out_ready),
      .gnt(gnt), .sel(sel), .out(out),
      .out_valid(out_valid), .busy(busy)
   );

   function automatic logic [WIDTH-1:0] dat(input int ch);
      case (ch)
         0:       return 4'h0;
         1:       return 4'h5;
         2:       return 4'hA;
         default: return 4'hF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_grant(input string tag, input int ch);
      logic [3:0] oh;
      oh = 4'b0001 << ch;
      chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
      chk({tag, ".sel"}, 32'(sel), 32'(ch));
      chk({tag, ".out"}, 32'(out), 32'(dat(ch)));
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"}, 32'(gnt), 32'd0);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: run did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order [5];
      logic [5:0] bp;
      a = 4'h0; b = 4'h5; c = 4'hA; d = 4'hF;
      rst = 1'b1; req = 4'b1111; out_ready = 1'b1;

      // Two reset edges with every request high, then the first grant goes to channel 0.
      tick(); chk_idle("rst1"); chk("rst1.sel", 32'(sel), 32'd0);
      tick(); chk_idle("rst2"); chk("rst2.sel", 32'(sel), 32'd0);
      rst = 1'b0;
      tick(); chk_grant("first", 0);

`ifdef MUX_ARB_FIXED_PRIO_EN
      for (int g = 0; g < 3; g++) begin
         for (int beat = 0; beat < MAX_BURST; beat++) begin
            chk_grant($sformatf("fp%0d_b%0d", g, beat), 0);
            tick();
         end
         chk_idle($sformatf("fp%0d_bubble", g));
         tick();
      end
      chk_grant("fp_next", 0);
`else
      // Full bursts with all requests held: rotation 0,1,2,3,0 with one idle bubble each.
      order = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
         for (int beat = 0; beat < MAX_BURST; beat++) begin
            chk_grant($sformatf("rot%0d_b%0d", g, beat), order[g]);
            tick();
         end
         chk_idle($sformatf("rot%0d_bubble", g));
         tick();
      end

      // Channel 1 now granted; drop its request after two accepted beats.
      chk_grant("er_b1", 1); tick();
      chk_grant("er_b2", 1); tick();
      chk_grant("er_hold", 1);
      req = 4'b1001;
      #1;
      chk("er_drop.valid", 32'(out_valid), 32'd0);
      tick(); chk_idle("er_rel");
      tick(); chk_grant("er_next", 3);

      // Sole requester on channel 3 is re-granted after exactly one bubble.
      req = 4'b1000;
      for (int beat = 0; beat < MAX_BURST; beat++) begin
         chk_grant($sformatf("sole_b%0d", beat), 3);
         tick();
      end
      chk_idle("sole_bubble");
      tick(); chk_grant("sole_regrant", 3);

      // Hand over to channel 2 through an early release.
      req = 4'b0100;
      #1;
      chk("to2.valid", 32'(out_valid), 32'd0);
      tick(); chk_idle("to2_rel");
      tick(); chk_grant("to2_gnt", 2);

      // Backpressure 1,0,0,1,1,1: four beats land, grant held for all six cycles.
      bp = 6'b111001;
      for (int i = 0; i < 6; i++) begin
         out_ready = bp[i];
         #1;
         chk_grant($sformatf("bp%0d", i), 2);
         tick();
      end
      chk_idle("bp_rel");
      out_ready = 1'b1;

      // Mid-burst reset during beat 2 of a channel 2 grant.
      tick(); chk_grant("mr_b1", 2);
      tick(); chk_grant("mr_b2", 2);
      rst = 1'b1;
      req = 4'b1111;
      tick(); chk_idle("mr_rst"); chk("mr_rst.sel", 32'(sel), 32'd0);
      rst = 1'b0;
      tick(); chk_grant("mr_first", 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
